// File: rtl/tracker_clk_pkg.sv
// Shared definitions for the tracker PLL sequencer: state encoding and 12 MHz timing defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tracker_clk_pkg;

    // 3-bit state encoding; codes 5..7 are illegal and recover to HOLD.
    localparam logic [2:0] ST_HOLD_ENC      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK_ENC = 3'd1;
    localparam logic [2:0] ST_STABLE_ENC    = 3'd2;
    localparam logic [2:0] ST_RUN_ENC       = 3'd3;
    localparam logic [2:0] ST_FAIL_ENC      = 3'd4;

    typedef enum logic [2:0] {
        ST_HOLD      = ST_HOLD_ENC,
        ST_WAIT_LOCK = ST_WAIT_LOCK_ENC,
        ST_STABLE    = ST_STABLE_ENC,
        ST_RUN       = ST_RUN_ENC,
        ST_FAIL      = ST_FAIL_ENC
    } state_t;

    // Timing defaults for a 12 MHz reference clock.
    localparam int PLL_RESET_CYCLES_12M    = 12;    // 1 us
    localparam int LOCK_TIMEOUT_CYCLES_12M = 1200;  // 100 us
    localparam int LOCK_STABLE_CYCLES_12M  = 64;
    localparam int MAX_RETRIES_DEF         = 3;
    localparam int CNT_W_DEF               = 11;

    // The PLL is out of reset while acquiring lock or running.
    function automatic logic pll_running(input state_t s);
        return (s == ST_WAIT_LOCK) || (s == ST_STABLE) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/tracker_pll_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the local clock domain.
// Latency: q follows d after 2 clock edges.
// Backpressure: none; level signal, always sampled.
//
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops to 0
//   d   - asynchronous input level
//   q   - synchronized output level
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tracker_pll_sequencer.sv
// Tracker PLL power-up/recovery sequencer: holds PLL in reset, waits for and qualifies lock, releases core reset.
// Latency: all outputs registered; PLL_LOCK decisions lag the pin by 2 cycles (synchronizer), outputs update 1 cycle after a decision.
// Backpressure: none; free-running supervisor, CLEAR_STATUS is a one-cycle pulse.
//
// Ports:
//   REFERENCECLK  in  12 MHz reference clock (only clock)
//   RESET         in  synchronous active-high reset
//   PLL_LOCK      in  raw PLL lock, asynchronous
//   CLEAR_STATUS  in  pulse, clears LOSS_OF_LOCK (a same-cycle set wins)
//   PLL_RESETB    out active-low PLL reset
//   CORE_RESET    out active-high reset for tracker logic
//   READY         out PLL locked and qualified
//   FAIL          out retries exhausted, sticky until RESET
//   LOSS_OF_LOCK  out sticky, lock dropped while running
//   RETRY_COUNT   out lock timeouts in the current sequence
module tracker_pll_sequencer
    import tracker_clk_pkg::*;
#(
    parameter int PLL_RESET_CYCLES    = PLL_RESET_CYCLES_12M,
    parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_12M,
    parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_12M,
    parameter int MAX_RETRIES         = MAX_RETRIES_DEF,
    parameter int CNT_W               = CNT_W_DEF
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       CLEAR_STATUS,
    output logic       PLL_RESETB,
    output logic       CORE_RESET,
    output logic       READY,
    output logic       FAIL,
    output logic       LOSS_OF_LOCK,
    output logic [3:0] RETRY_COUNT
);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    logic             lock_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             lol_set;

    sync_2ff u_lock_sync (
        .clk (REFERENCECLK),
        .rst (RESET),
        .d   (PLL_LOCK),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = RETRY_COUNT;
        lol_set   = 1'b0;

        case (state)
            ST_HOLD: begin
                if (cnt >= HOLD_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                // Lock seen here is already the first qualifying high cycle,
                // so STABLE starts counting from one. Lock also beats timeout.
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = CNT_ONE;
                end else if (cnt >= TIMEOUT_LAST) begin
                    cnt_nxt   = '0;
                    retry_nxt = RETRY_COUNT + 4'd1;
                    state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAIL : ST_HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_STABLE: begin
                // A glitch restarts acquisition with a fresh timeout but is
                // not treated as a failed attempt.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt >= STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    retry_nxt = 4'd0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                    lol_set   = 1'b1;
                end
            end

            ST_FAIL: begin
                retry_nxt = RETRY_MAX;
            end

            default: begin
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register rather than one cycle behind it.
    always_ff @(posedge REFERENCECLK) begin
        if (RESET) begin
            state        <= ST_HOLD;
            cnt          <= '0;
            RETRY_COUNT  <= 4'd0;
            PLL_RESETB   <= 1'b0;
            CORE_RESET   <= 1'b1;
            READY        <= 1'b0;
            FAIL         <= 1'b0;
            LOSS_OF_LOCK <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            RETRY_COUNT  <= retry_nxt;
            PLL_RESETB   <= pll_running(state_nxt);
            CORE_RESET   <= (state_nxt != ST_RUN);
            READY        <= (state_nxt == ST_RUN);
            FAIL         <= (state_nxt == ST_FAIL);
            LOSS_OF_LOCK <= lol_set | (LOSS_OF_LOCK & ~CLEAR_STATUS);
        end
    end

endmodule

// File: tb/tb_tracker_pll_sequencer.sv
// Self-checking bench for tracker_pll_sequencer: directed scenarios then randomized lock/clear/reset traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_tracker_pll_sequencer;

    localparam int PRC = 4;
    localparam int LTC = 20;
    localparam int LSC = 8;
    localparam int MR  = 2;

    localparam int M_HOLD = 0;  // PLL held in reset
    localparam int M_ACQ  = 1;  // PLL released, acquiring/qualifying lock
    localparam int M_RUN  = 2;
    localparam int M_DEAD = 3;  // retries exhausted

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       clear_status;
    logic       pll_resetb;
    logic       core_reset;
    logic       ready;
    logic       fail;
    logic       loss_of_lock;
    logic [3:0] retry_count;

    always #5 clk = ~clk;

    tracker_pll_sequencer #(
        .PLL_RESET_CYCLES    (PRC),
        .LOCK_TIMEOUT_CYCLES (LTC),
        .LOCK_STABLE_CYCLES  (LSC),
        .MAX_RETRIES         (MR),
        .CNT_W               (11)
    ) dut (
        .REFERENCECLK (clk),
        .RESET        (rst),
        .PLL_LOCK     (pll_lock),
        .CLEAR_STATUS (clear_status),
        .PLL_RESETB   (pll_resetb),
        .CORE_RESET   (core_reset),
        .READY        (ready),
        .FAIL         (fail),
        .LOSS_OF_LOCK (loss_of_lock),
        .RETRY_COUNT  (retry_count)
    );

    // Reference model: phase-level view. Lock history is kept as raw pin
    // samples; the synchronized view is the sample from two cycles earlier.
    int m_mode;
    int m_cyc;
    int m_start;
    int m_wstart;
    int m_streak;
    int m_retries;
    bit m_lol;
    bit hist[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [8:0] obs_vec();
        return {pll_resetb, core_reset, ready, fail, loss_of_lock, retry_count};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {(m_mode == M_ACQ) || (m_mode == M_RUN), m_mode != M_RUN, m_mode == M_RUN,
                m_mode == M_DEAD, m_lol, 4'(m_retries)};
    endfunction

    task automatic model_advance();
        bit s;
        bit set_lol;
        if (rst) begin
            m_mode    = M_HOLD;
            m_cyc     = 0;
            m_start   = 0;
            m_wstart  = 0;
            m_streak  = 0;
            m_retries = 0;
            m_lol     = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(pll_lock);
            s       = (m_cyc >= 2) ? hist[m_cyc - 2] : 1'b0;
            set_lol = 1'b0;
            case (m_mode)
                M_HOLD: begin
                    if (m_cyc - m_start == PRC - 1) begin
                        m_mode   = M_ACQ;
                        m_wstart = m_cyc + 1;
                        m_streak = 0;
                    end
                end
                M_ACQ: begin
                    if (s) begin
                        m_streak++;
                        if (m_streak == LSC) begin
                            m_mode    = M_RUN;
                            m_retries = 0;
                        end
                    end else if (m_streak > 0) begin
                        m_streak = 0;
                        m_wstart = m_cyc + 1;
                    end else if (m_cyc - m_wstart == LTC - 1) begin
                        m_retries++;
                        if (m_retries == MR) m_mode = M_DEAD;
                        else begin
                            m_mode  = M_HOLD;
                            m_start = m_cyc + 1;
                        end
                    end
                end
                M_RUN: begin
                    if (!s) begin
                        m_mode  = M_HOLD;
                        m_start = m_cyc + 1;
                        set_lol = 1'b1;
                    end
                end
                default: ;
            endcase
            m_lol = set_lol ? 1'b1 : (clear_status ? 1'b0 : m_lol);
            m_cyc++;
        end
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        chk("cycle", obs_vec(), exp_vec());
    endtask

    task automatic do_reset(input int n);
        rst          = 1'b1;
        pll_lock     = 1'b0;
        clear_status = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        int first_rb;
        int first_rdy;
        int first_core_lo;
        int lo_cnt;
        int seg;
        logic early;
        logic [8:0] snap;

        rst          = 1'b1;
        pll_lock     = 1'b0;
        clear_status = 1'b0;

        // Reset state
        do_reset(3);
        chk("reset_state", obs_vec(), 9'b0_1_0_0_0_0000);

        // Scenario 1: lock on cycle 10
        first_rb = -1; first_rdy = -1; first_core_lo = -1;
        for (int c = 0; c < 26; c++) begin
            if (pll_resetb && first_rb < 0) first_rb = c;
            if (ready && first_rdy < 0) first_rdy = c;
            if (!core_reset && first_core_lo < 0) first_core_lo = c;
            pll_lock = (c >= 10);
            step();
        end
        chk("s1_resetb_rise", 9'(first_rb), 9'd4);
        chk("s1_ready_first", 9'(first_rdy), 9'd20);
        chk("s1_core_low_first", 9'(first_core_lo), 9'd20);
        chk("s1_retry", 9'(retry_count), 9'd0);

        // Scenario 2: no lock -> retry, then FAIL
        do_reset(2);
        lo_cnt = 0;
        snap   = '0;
        for (int c = 0; c < 70; c++) begin
            if (c == 24) snap = 9'(retry_count);
            if (c >= 20 && c < 32 && !pll_resetb) lo_cnt++;
            pll_lock = 1'b0;
            step();
        end
        chk("s2_retry_after_first_timeout", snap, 9'd1);
        chk("s2_second_hold_len", 9'(lo_cnt), 9'd4);
        chk("s2_fail", {fail, retry_count, 4'b0}, {1'b1, 4'd2, 4'b0});
        for (int c = 0; c < 20; c++) begin
            pll_lock = 1'b1;
            step();
        end
        chk("s2_fail_sticky", {pll_resetb, fail, ready, 6'b0}, {1'b0, 1'b1, 1'b0, 6'b0});

        // Scenario 3: glitch after 5 qualified highs, then relock
        do_reset(2);
        early = 1'b0;
        snap  = '0;
        for (int c = 0; c < 25; c++) begin
            if (c <= 17 && ready) early = 1'b1;
            if (c == 18) snap = {ready, retry_count, 4'b0};
            pll_lock = (c != 7);
            step();
        end
        chk("s3_no_early_ready", 9'(early), 9'd0);
        chk("s3_ready_at_18", snap, {1'b1, 4'd0, 4'b0});

        // Scenarios 4/5: loss of lock in RUN, clear collision, later clear
        lo_cnt = 0;
        for (int c = 25; c < 60; c++) begin
            if (c == 28) chk("s4_lol_outputs", {ready, core_reset, loss_of_lock, pll_resetb, 5'b0},
                             {4'b0110, 5'b0});
            if (c >= 26 && c < 36 && !pll_resetb) lo_cnt++;
            if (c == 39) chk("s4_not_ready_39", 9'(ready), 9'd0);
            if (c == 40) chk("s4_ready_again", {ready, loss_of_lock, 7'b0}, {2'b11, 7'b0});
            if (c == 45) chk("s5_lol_before_clear", 9'(loss_of_lock), 9'd1);
            if (c == 46) chk("s5_lol_cleared", 9'(loss_of_lock), 9'd0);
            pll_lock     = (c != 25);
            clear_status = (c == 27) || (c == 45);
            step();
        end
        clear_status = 1'b0;
        chk("s4_hold_len", 9'(lo_cnt), 9'd4);

        // Scenario 6: reset mid-WAIT_LOCK and mid-RUN
        do_reset(1);
        for (int c = 0; c < 10; c++) begin
            pll_lock = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        chk("s6_reset_in_wait", obs_vec(), 9'b0_1_0_0_0_0000);
        rst = 1'b0;
        lo_cnt = 0;
        for (int c = 0; c < 41; c++) begin
            if (c < 8 && !pll_resetb) lo_cnt++;
            pll_lock = (c != 20);
            step();
        end
        chk("s6_hold_len_after_wait_reset", 9'(lo_cnt), 9'd4);
        chk("s6_in_run_with_lol", {ready, loss_of_lock, 7'b0}, {2'b11, 7'b0});
        rst = 1'b1;
        step();
        chk("s6_reset_in_run", obs_vec(), 9'b0_1_0_0_0_0000);
        rst = 1'b0;
        lo_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (!pll_resetb) lo_cnt++;
            step();
        end
        chk("s6_hold_len_after_run_reset", 9'(lo_cnt), 9'd4);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n += seg) begin
            if ($urandom_range(0, 3) != 0) begin
                pll_lock = 1'b1;
                seg      = $urandom_range(5, 120);
            end else begin
                pll_lock = 1'b0;
                seg      = $urandom_range(1, 40);
            end
            for (int k = 0; k < seg; k++) begin
                clear_status = ($urandom_range(0, 15) == 0);
                rst          = ($urandom_range(0, 299) == 0);
                step();
            end
        end
        rst          = 1'b0;
        clear_status = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tracker_pll_sequencer.md
Name: tracker_pll_sequencer

Overview:
Power-up and recovery sequencer that drives the tracker PLL's active-low reset and supervises its lock output. It sits directly upstream of the tracker PLL wrapper and runs from the same 12 MHz reference clock. It holds the PLL in reset for a fixed time, waits for lock, and qualifies lock as stable. Only then does it release the core reset for the tracker logic. It retries the PLL on lock timeout, flags permanent failure, and re-sequences on loss of lock.

Parameters:
PLL_RESET_CYCLES, 12, cycles PLL_RESETB is held low per attempt (1 us at 12 MHz); must be >= 1
LOCK_TIMEOUT_CYCLES, 1200, max cycles to wait for synchronized lock after PLL_RESETB release (100 us)
LOCK_STABLE_CYCLES, 64, consecutive synchronized-lock-high cycles required before READY
MAX_RETRIES, 3, lock timeouts tolerated before FAIL; range 1..15
CNT_W, 11, internal counter width; must hold max(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)

Ports:
REFERENCECLK  in   1  12 MHz reference clock; the only clock
RESET         in   1  synchronous, active-high reset
PLL_LOCK      in   1  raw PLL lock, asynchronous to REFERENCECLK
CLEAR_STATUS  in   1  one-cycle pulse; clears LOSS_OF_LOCK
PLL_RESETB    out  1  active-low reset to PLL (RESETB pin)
CORE_RESET    out  1  active-high reset for tracker logic; downstream synchronizes into the PLL clock domain
READY         out  1  PLL locked and qualified
FAIL          out  1  retries exhausted; sticky until RESET
LOSS_OF_LOCK  out  1  sticky; lock dropped while in RUN
RETRY_COUNT   out  4  lock timeouts in the current sequence

Behaviour:
- Reset (RESET=1 at edge): state=HOLD, counters=0, PLL_RESETB=0, CORE_RESET=1, READY=0, FAIL=0, LOSS_OF_LOCK=0, RETRY_COUNT=0, synchronizer flops=0. Reset applied in any state aborts the operation immediately.
- PLL_LOCK passes through a 2-flop synchronizer. lock_s lags PLL_LOCK by 2 cycles. All decisions use lock_s only.
- All outputs are registered.
- HOLD:
  - PLL_RESETB=0, CORE_RESET=1, READY=0.
  - The counter counts cycles. After PLL_RESET_CYCLES cycles in HOLD, go to WAIT_LOCK. PLL_RESETB reads 1 from the first WAIT_LOCK cycle.
  - From RESET release, PLL_RESETB is low for exactly PLL_RESET_CYCLES cycles.
- WAIT_LOCK:
  - PLL_RESETB=1. The counter restarts at 0.
  - lock_s=1 -> STABLE.
  - If the counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0, RETRY_COUNT increments. If the new value equals MAX_RETRIES -> FAIL, else -> HOLD.
  - If lock arrives on the timeout cycle, lock wins.
- STABLE:
  - The counter counts consecutive lock_s=1 cycles.
  - lock_s=0 -> back to WAIT_LOCK with a fresh timeout. No retry increment.
  - After LOCK_STABLE_CYCLES consecutive highs -> RUN. On the first RUN cycle, READY=1, CORE_RESET=0 and RETRY_COUNT=0.
- RUN:
  - Holds READY=1, CORE_RESET=0.
  - A single lock_s=0 cycle triggers re-sequencing. On the next cycle, READY=0, CORE_RESET=1, LOSS_OF_LOCK=1, PLL_RESETB=0, state=HOLD.
- FAIL:
  - PLL_RESETB=0, CORE_RESET=1, READY=0, FAIL=1, RETRY_COUNT=MAX_RETRIES.
  - Exit only via RESET. PLL_LOCK is ignored.
- CLEAR_STATUS clears LOSS_OF_LOCK on the next cycle. If set and clear occur in the same cycle, set wins. CLEAR_STATUS has no effect on FAIL or the state.
- Counter arithmetic: unsigned CNT_W, no wrap. Each state's terminal count forces a transition before overflow.
- Illegal state encoding -> HOLD (PLL_RESETB=0, CORE_RESET=1).

Decomposition:
- Shared package tracker_clk_pkg holds:
  - the state encoding localparams (HOLD, WAIT_LOCK, STABLE, RUN, FAIL; 3-bit);
  - default timing constants for 12 MHz.
- One natural sub-module: sync_2ff (2-flop synchronizer, 1-bit, synchronous active-high reset to 0), instantiated for PLL_LOCK.

Test Plan:
All scenarios use PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release RESET, then assert PLL_LOCK=1 on cycle 10 -> PLL_RESETB rises on cycle 4. READY and CORE_RESET=0 first appear on cycle 10+2+8=20. RETRY_COUNT=0.
2. Keep PLL_LOCK=0 -> timeout, RETRY_COUNT=1, PLL_RESETB low again for 4 cycles. Second timeout -> FAIL=1, RETRY_COUNT=2, PLL_RESETB stays 0 despite a later PLL_LOCK=1.
3. In STABLE, drop PLL_LOCK for 1 cycle after 5 highs -> no READY, RETRY_COUNT unchanged. Relock held 8 cycles -> READY.
4. In RUN, drop PLL_LOCK for 1 cycle -> 2+1 cycles later READY=0, CORE_RESET=1, LOSS_OF_LOCK=1, PLL_RESETB=0 for 4 cycles. Lock returns -> READY again, LOSS_OF_LOCK still 1.
5. Pulse CLEAR_STATUS in the same cycle as a loss-of-lock set -> LOSS_OF_LOCK=1. A separate later pulse -> 0.
6. Assert RESET mid-WAIT_LOCK and mid-RUN -> next cycle all outputs at reset values. The full sequence restarts with PLL_RESETB low for 4 cycles.
